// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch controller and its buffer.
package fetch_pkg;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFault
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order fetch buffer with push/pop/flush; head data reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  fetch_entry_t    mem_q [DEPTH];
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntFull);
  assign empty_o = (cnt_q == '0);

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (do_push && !do_pop) cnt_d = cnt_q + CntOne;
      if (do_pop && !do_push) cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    rdata_o = '0;
    if (!empty_o) rdata_o = mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch FSM and PC feeding a 2-entry fetch buffer.
// Optional range check against MEM_WORDS enabled by IMEM_FETCH_BOUND_CHECK_EN.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned       MEM_WORDS = 50,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ReadAddress,
  input  logic [WORD_W-1:0] Instruction,
  output logic [WORD_W-1:0] InstrOut,
  output logic [ADDR_W-1:0] PCOut,
  output logic              InstrValid,
  input  logic              InstrReady,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectTarget,
  output logic              Busy,
  output logic              Fault
);

`ifdef IMEM_FETCH_BOUND_CHECK_EN
  localparam bit BoundCheck = 1'b1;
`else
  localparam bit BoundCheck = 1'b0;
`endif

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push, pop, flush, full, empty, range_err;
  fetch_entry_t      wdata, rdata;

  assign range_err = BoundCheck && ({2'b00, pc_q[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS));
  assign pop       = !empty && InstrReady;
  assign wdata     = '{pc: pc_q, instr: Instruction};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Redirect) begin
          flush = 1'b1;
          pc_d  = RedirectTarget & 32'hFFFF_FFFC;
        end
        if (start) state_d = StFetch;
      end
      StFetch: begin
        // Redirect wins over the range check so a jump back into memory never faults.
        if (Redirect) begin
          flush = 1'b1;
          pc_d  = RedirectTarget & 32'hFFFF_FFFC;
        end else if (range_err) begin
          state_d = StFault;
        end else if (!full || pop) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      StFault: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign ReadAddress = pc_q;
  assign InstrOut    = rdata.instr;
  assign PCOut       = rdata.pc;
  assign InstrValid  = !empty;
  assign Busy        = (state_q == StFetch);
  assign Fault       = BoundCheck && (state_q == StFault);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a combinational instruction memory model.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] ReadAddress;
  logic [31:0] Instruction;
  logic [31:0] InstrOut;
  logic [31:0] PCOut;
  logic        InstrValid;
  logic        InstrReady;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        Busy;
  logic        Fault;

  int checks = 0;
  int errors = 0;

  imem_fetch_ctrl #(
    .MEM_WORDS (50),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .ReadAddress    (ReadAddress),
    .Instruction    (Instruction),
    .InstrOut       (InstrOut),
    .PCOut          (PCOut),
    .InstrValid     (InstrValid),
    .InstrReady     (InstrReady),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .Busy           (Busy),
    .Fault          (Fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: mem_word = 32'h0000_0000;
      32'h0000_0004: mem_word = 32'h2008_0020;
      32'h0000_0008: mem_word = 32'h2009_0037;
      default:       mem_word = {8'hA5, addr[23:0]};
    endcase
  endfunction

  always_comb Instruction = mem_word(ReadAddress);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; InstrReady = 1'b0; Redirect = 1'b0; RedirectTarget = '0;
    tick; tick;

    // Reset state
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_instr", InstrOut, 32'd0);
    chk("rst_pcout", PCOut, 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);
    chk("rst_raddr", ReadAddress, 32'd0);

    // Streaming fetch with decode always ready
    rst_n = 1'b1; start = 1'b1; InstrReady = 1'b1;
    tick;  // N+1
    start = 1'b0;
    chk("s_busy", 32'(Busy), 32'd1);
    chk("s_n1_valid", 32'(InstrValid), 32'd0);
    tick;  // N+2
    chk("s_v0", 32'(InstrValid), 32'd1);
    chk("s_pc0", PCOut, 32'h0);
    chk("s_in0", InstrOut, 32'h0);
    tick;
    chk("s_v1", 32'(InstrValid), 32'd1);
    chk("s_pc1", PCOut, 32'h4);
    chk("s_in1", InstrOut, 32'h2008_0020);
    tick;
    chk("s_pc2", PCOut, 32'h8);
    chk("s_in2", InstrOut, 32'h2009_0037);

    // Backpressure: buffer fills with two entries and PC holds
    rst_n = 1'b0; tick;
    rst_n = 1'b1; start = 1'b1; InstrReady = 1'b0;
    tick;  // N+1
    start = 1'b0;
    tick;  // N+2
    chk("bp_ra_n2", ReadAddress, 32'h4);
    tick;  // N+3
    chk("bp_ra_n3", ReadAddress, 32'h8);
    tick;  // N+4
    chk("bp_ra_n4", ReadAddress, 32'h8);
    tick;  // N+5
    chk("bp_ra_n5", ReadAddress, 32'h8);
    chk("bp_head0", PCOut, 32'h0);
    InstrReady = 1'b1;
    tick;
    chk("bp_head1", PCOut, 32'h4);
    chk("bp_ra_rel", ReadAddress, 32'hC);
    tick;
    chk("bp_head2", PCOut, 32'h8);
    chk("bp_in2", InstrOut, 32'h2009_0037);

    // Redirect with two entries buffered and a concurrent pop
    rst_n = 1'b0; tick;
    rst_n = 1'b1; start = 1'b1; InstrReady = 1'b0;
    tick; start = 1'b0;
    tick; tick;  // N+3, full
    chk("rd_full_pc", PCOut, 32'h0);
    Redirect = 1'b1; RedirectTarget = 32'h0000_005E; InstrReady = 1'b1;
    tick;
    Redirect = 1'b0;
    chk("rd_flush_valid", 32'(InstrValid), 32'd0);
    chk("rd_ra", ReadAddress, 32'h5C);
    chk("rd_busy", 32'(Busy), 32'd1);
    tick;
    chk("rd_head_pc", PCOut, 32'h5C);
    chk("rd_head_in", InstrOut, 32'hA500_005C);
    tick;
    chk("rd_next_pc", PCOut, 32'h60);

    // Reset mid-stream with a full buffer; reset beats start
    InstrReady = 1'b0;
    tick; tick;
    chk("mr_valid_pre", 32'(InstrValid), 32'd1);
    rst_n = 1'b0; start = 1'b1;
    tick;
    chk("mr_valid", 32'(InstrValid), 32'd0);
    chk("mr_ra", ReadAddress, 32'h0);
    chk("mr_busy", 32'(Busy), 32'd0);
    chk("mr_pcout", PCOut, 32'h0);
    rst_n = 1'b1; start = 1'b0;
    tick;
    chk("mr_idle_busy", 32'(Busy), 32'd0);
    chk("mr_idle_valid", 32'(InstrValid), 32'd0);

    // Last memory word and the first address past it
    Redirect = 1'b1; RedirectTarget = 32'h0000_00C4;
    tick;
    Redirect = 1'b0;
    chk("b_ra_idle", ReadAddress, 32'hC4);
    chk("b_idle_busy", 32'(Busy), 32'd0);
    start = 1'b1; InstrReady = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("b_head_pc", PCOut, 32'hC4);
    chk("b_head_in", InstrOut, 32'hA500_00C4);
    chk("b_ra_c8", ReadAddress, 32'hC8);
    tick;
`ifdef IMEM_FETCH_BOUND_CHECK_EN
    chk("b_fault", 32'(Fault), 32'd1);
    chk("b_fault_busy", 32'(Busy), 32'd0);
    chk("b_fault_valid", 32'(InstrValid), 32'd0);
    Redirect = 1'b1; RedirectTarget = 32'h0000_0010;
    tick;
    Redirect = 1'b0;
    chk("b_fault_ra", ReadAddress, 32'hC8);
    chk("b_fault_hold", 32'(Fault), 32'd1);
    chk("b_fault_novalid", 32'(InstrValid), 32'd0);
`else
    chk("b_nofault", 32'(Fault), 32'd0);
    chk("b_pc_c8", PCOut, 32'hC8);
    chk("b_valid_c8", 32'(InstrValid), 32'd1);
    tick;
    chk("b_pc_cc", PCOut, 32'hCC);
    chk("b_nofault2", 32'(Fault), 32'd0);
`endif

    // PC wrap at the top of the address space
    rst_n = 1'b0; InstrReady = 1'b0; tick;
    rst_n = 1'b1;
`ifndef IMEM_FETCH_BOUND_CHECK_EN
    Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFC;
    tick;
    Redirect = 1'b0;
    chk("w_ra", ReadAddress, 32'hFFFF_FFFC);
    start = 1'b1; InstrReady = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("w_pc_top", PCOut, 32'hFFFF_FFFC);
    chk("w_ra_wrap", ReadAddress, 32'h0);
    tick;
    chk("w_valid", 32'(InstrValid), 32'd1);
    chk("w_pc_zero", PCOut, 32'h0);
    chk("w_in_zero", InstrOut, 32'h0);
    tick;
    chk("w_pc_four", PCOut, 32'h4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
